// File: rtl/hk_game_pkg.sv
// Shared game-wide types and constants: state encoding, USB keycodes,
// and the saturating life decrement used by the life manager.
package hk_game_pkg;

    typedef enum logic [2:0] {
        ST_TITLE   = 3'd0,
        ST_PLAY    = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_RESPAWN = 3'd3,
        ST_OVER    = 3'd4
    } game_state_e;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;

    function automatic logic [3:0] life_dec(input logic [3:0] l);
        return (l == 4'd0) ? 4'd0 : l - 4'd1;
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Per-frame down counter with load, enable and hold; sticks at zero
// and flags it so callers can test expiry without a comparator.
module frame_down_counter #(
    parameter int W = 8
) (
    input  logic         frame_clk,
    input  logic         Reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/player_life_manager.sv
// Game flow and life bookkeeping: title, play, pause, respawn and
// game-over sequencing, with a hit-immunity window after damage.
module player_life_manager
    import hk_game_pkg::*;
#(
    parameter logic [3:0] INIT_LIFE      = 4'd3,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd60,
    parameter logic [7:0] INVULN_FRAMES  = 8'd90,
    parameter logic [7:0] OVER_FRAMES    = 8'd120
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       fall_event,
    input  logic       hit_event,
    output logic       respawn,
    output logic       freeze,
    output logic       invincible,
    output logic       blink,
    output logic [3:0] life,
    output logic [2:0] game_state
);

    game_state_e state_q, state_d;
    logic [3:0]  life_q, life_d;
    logic        respawn_d;
    logic [7:0]  prev_key;

    logic        enter_edge, esc_edge;

    logic        tmr_load, tmr_en, tmr_zero;
    logic [7:0]  tmr_val, tmr_count;
    logic        inv_load, inv_en, inv_zero;
    logic [7:0]  inv_val, inv_count;

    assign enter_edge = (keycode == KEY_ENTER) && (prev_key != KEY_ENTER);
    assign esc_edge   = (keycode == KEY_ESC) && (prev_key != KEY_ESC);

    frame_down_counter #(.W(8)) u_timer (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .en        (tmr_en),
        .count     (tmr_count),
        .zero      (tmr_zero)
    );

    frame_down_counter #(.W(8)) u_invuln (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .load      (inv_load),
        .load_val  (inv_val),
        .en        (inv_en),
        .count     (inv_count),
        .zero      (inv_zero)
    );

    always_comb begin
        state_d   = state_q;
        life_d    = life_q;
        respawn_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = 8'd0;
        tmr_en    = 1'b0;
        inv_load  = 1'b0;
        inv_val   = 8'd0;
        inv_en    = 1'b0;

        unique case (state_q)
            ST_TITLE: begin
                life_d   = INIT_LIFE;
                inv_load = 1'b1;
                if (enter_edge) begin
                    state_d   = ST_PLAY;
                    respawn_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // Immunity is held on the pause frame so it resumes exactly.
                inv_en = !esc_edge;
                if (fall_event) begin
                    life_d = life_dec(life_q);
                    if (life_q > 4'd1) begin
                        state_d  = ST_RESPAWN;
                        tmr_load = 1'b1;
                        tmr_val  = RESPAWN_FRAMES;
                    end
                end else if (hit_event && inv_zero) begin
                    life_d   = life_dec(life_q);
                    inv_load = 1'b1;
                    inv_val  = INVULN_FRAMES;
                end else if (esc_edge) begin
                    inv_en  = 1'b0;
                    state_d = ST_PAUSE;
                end
                if ((fall_event || (hit_event && inv_zero)) && life_q <= 4'd1) begin
                    state_d  = ST_OVER;
                    tmr_load = 1'b1;
                    tmr_val  = OVER_FRAMES;
                    inv_load = 1'b1;
                    inv_val  = 8'd0;
                end
            end
            ST_PAUSE: begin
                if (esc_edge) begin
                    state_d = ST_PLAY;
                end
            end
            ST_RESPAWN: begin
                if (tmr_zero) begin
                    state_d   = ST_PLAY;
                    respawn_d = 1'b1;
                    inv_load  = 1'b1;
                    inv_val   = INVULN_FRAMES;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_OVER: begin
                life_d   = 4'd0;
                inv_load = 1'b1;
                tmr_en   = 1'b1;
                if (enter_edge && tmr_zero) begin
                    state_d = ST_TITLE;
                    life_d  = INIT_LIFE;
                end
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_TITLE;
            life_q   <= INIT_LIFE;
            respawn  <= 1'b0;
            freeze   <= 1'b1;
            prev_key <= 8'h00;
        end else begin
            state_q  <= state_d;
            life_q   <= life_d;
            respawn  <= respawn_d;
            freeze   <= (state_d != ST_PLAY);
            prev_key <= keycode;
        end
    end

    assign invincible = !inv_zero;
    assign blink      = !inv_zero && inv_count[2];
    assign life       = life_q;
    assign game_state = state_q;

endmodule

// File: doc/player_life_manager.md
PLAYER_LIFE_MANAGER -- requirements
Module: player_life_manager

Interface
REQ-001 SHALL have parameter INIT_LIFE, default 4'd3, lives loaded at game start.
REQ-002 SHALL have parameter RESPAWN_FRAMES, default 8'd60, frozen frames after a fall.
REQ-003 SHALL have parameter INVULN_FRAMES, default 8'd90, frames of hit immunity.
REQ-004 SHALL have parameter OVER_FRAMES, default 8'd120, minimum game-over display frames.
REQ-005 SHALL have port frame_clk  input  1  single clock, one edge per video frame.
REQ-006 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port keycode  input  8  current USB keycode; 8'h28 = Enter, 8'h29 = Esc.
REQ-008 SHALL have port fall_event  input  1  one-frame pulse: player entered a trap.
REQ-009 SHALL have port hit_event  input  1  level: player overlaps an enemy or projectile.
REQ-010 SHALL have port respawn  output  1  one-frame pulse: player block reloads its centre position.
REQ-011 SHALL have port freeze  output  1  player block ignores keycode and holds its motion.
REQ-012 SHALL have port invincible  output  1  invulnerability counter nonzero.
REQ-013 SHALL have port blink  output  1  sprite hide strobe.
REQ-014 SHALL have port life  output  4  remaining lives.
REQ-015 SHALL have port game_state  output  3  TITLE=0, PLAY=1, PAUSE=2, RESPAWN=3, OVER=4.

Function
REQ-016 SHALL detect Enter and Esc only on rising edges: key now equal, previous-frame keycode not equal.
REQ-017 SHALL, in TITLE, hold life=INIT_LIFE and freeze=1; on Enter edge go to PLAY and assert respawn for that transition frame.
REQ-018 SHALL, in PLAY with fall_event=1, decrement life by one; go to OVER when the old life is 1, otherwise load the frame counter with RESPAWN_FRAMES and go to RESPAWN.
REQ-019 SHALL, in PLAY with hit_event=1 and invuln counter 0, decrement life and load invuln counter with INVULN_FRAMES; go to OVER when the old life is 1.
REQ-020 SHALL ignore hit_event while the invuln counter is nonzero.
REQ-021 SHALL treat simultaneous fall_event and hit_event as a single fall: one decrement, REQ-018 path.
REQ-022 SHALL saturate life at 0; it never wraps.
REQ-023 SHALL, in PLAY, go to PAUSE on Esc edge. In PAUSE: freeze=1, all counters hold. An Esc edge returns to PLAY. Events are ignored.
REQ-024 SHALL, in RESPAWN: freeze=1, decrement the frame counter each frame, ignore all events. On the frame the counter is 0: pulse respawn, load invuln with INVULN_FRAMES, go to PLAY.
REQ-025 SHALL, on entry to OVER, load the frame counter with OVER_FRAMES. In OVER: freeze=1, life=0, counter decrements. An Enter edge is honoured only when the counter is 0, going to TITLE.
REQ-026 SHALL decrement the invuln counter once per frame in PLAY only, saturating at 0. It holds in PAUSE and is cleared in TITLE and OVER.
REQ-027 SHALL drive invincible = (invuln counter != 0).
REQ-028 SHALL drive blink = invincible AND invuln counter bit 2.
REQ-029 SHALL register all outputs; a state change is visible on the frame after the triggering event.
REQ-030 SHALL drive freeze=0 only in PLAY.
REQ-031 SHALL make respawn exactly one frame wide and assert it only on TITLE->PLAY and RESPAWN->PLAY.

Reset
REQ-032 SHALL, on Reset_n low, asynchronously force: game_state=TITLE, life=INIT_LIFE, respawn=0, freeze=1, invincible=0, blink=0, all counters 0, previous-keycode register 8'h00.
REQ-033 SHALL resume from TITLE when reset is asserted mid-operation, with no pending respawn pulse.

Structure
REQ-034 SHALL take the game_state encoding and keycode constants (KEY_ENTER, KEY_ESC, KEY_LEFT 8'h50, KEY_RIGHT 8'h4F, KEY_UP 8'h52, KEY_DOWN 8'h51) from shared package hk_game_pkg.
REQ-035 SHALL instantiate one sub-module frame_down_counter: 8-bit, load/enable/hold, saturating at 0, zero flag. It is used for the respawn/over timer; the invuln counter is a second instance.

Verification
REQ-036 SHALL cover: reset, then keycode 8'h28 for 1 frame -> game_state 0->1, respawn high for exactly 1 frame, life=3.
REQ-037 SHALL cover: PLAY, fall_event pulse -> life 3->2, state RESPAWN, freeze=1 for 61 frames, then respawn pulse, state PLAY, invincible=1.
REQ-038 SHALL cover: PLAY, hit_event held 100 frames -> life decrements once. blink toggles every 4 frames. After 90 frames invincible=0, then a second decrement.
REQ-039 SHALL cover: life=1, fall_event and hit_event in the same frame -> life=0, state OVER. Enter at frame 50 is ignored. Enter after frame 120 -> TITLE, life=3.
REQ-040 SHALL cover: PLAY with invuln=40, Esc edge -> PAUSE, counter frozen for 30 frames. Esc held continuously causes no re-toggle. A second Esc edge -> PLAY, invuln resumes at 40.
REQ-041 SHALL cover: Reset_n low mid-RESPAWN -> immediate TITLE, all outputs at reset values, no respawn pulse after release.
